sipo_frame_ctrl: RTL
====================

# sipo_frame_ctrl

Frame controller for the 3-bit serial-in/parallel-out register path. It gates serial bits into a WIDTH-bit shift datapath on command, counts them, and presents each completed word on a valid/ready output port. It also drives a `shift_en` strobe so an external SIPO register can be stepped in lockstep. It sits between the serial bit source and the parallel-word consumer.

## Interface
- `WIDTH`, default 3: bits per frame; legal range ≥ 2.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: begin a frame; honoured only in IDLE.
- `sin` in 1: serial data bit.
- `bit_en` in 1: `sin` is valid this cycle.
- `dout_ready` in 1: consumer accepts `dout` this cycle.
- `clr_ovr` in 1: synchronous clear of `overrun`.
- `shift_en` out 1: combinational, equals `bit_en` while in SHIFT and 0 elsewhere; steps the external SIPO.
- `busy` out 1: high while in SHIFT.
- `bit_cnt` out `$clog2(WIDTH+1)`: number of bits accepted in the current frame.
- `dout` out WIDTH: completed word, with the first-received bit at the MSB.
- `dout_valid` out 1: `dout` holds an unconsumed word.
- `overrun` out 1: sticky; a completed word was dropped.

## Operation
- States: IDLE, SHIFT.
- IDLE:
  - `start`=1 moves to SHIFT next cycle and clears `bit_cnt` and the shift register to 0.
  - `bit_en` is ignored in IDLE, including when `start` and `bit_en` are high in the same cycle.
- SHIFT:
  - Each cycle with `bit_en`=1, the shift register does `sh <= {sh[WIDTH-2:0], sin}` (new bit into bit 0, older bits move up) and `bit_cnt` increments.
  - `start` is ignored in SHIFT.
- Frame completion occurs when `bit_en`=1 and `bit_cnt`==WIDTH-1. In that cycle the completed word is `{sh[WIDTH-2:0], sin}`. On the next edge:
  - the state returns to IDLE and `bit_cnt` returns to 0;
  - if `dout_valid`=0, or `dout_valid`=1 and `dout_ready`=1 in the completion cycle: `dout` <= completed word and `dout_valid` <= 1;
  - otherwise the new word is dropped, `dout` and `dout_valid` are unchanged, and `overrun` <= 1.
- Output handshake:
  - `dout_valid` falls on the edge after a cycle with `dout_valid`=1 and `dout_ready`=1, unless a new word loads on that same edge, in which case it stays 1.
  - `dout` is stable while `dout_valid`=1 and not consumed.
- `overrun` clears only on `clr_ovr`=1 or `reset`. If a set and `clr_ovr` occur in the same cycle, set wins.
- `dout_ready` has no effect while `dout_valid`=0.

## Timing
- Reset, asynchronous: state=IDLE, `bit_cnt`=0, shift register=0, `dout`=0, `dout_valid`=0, `overrun`=0, `busy`=0. `shift_en`=0, since it is combinational on the state.
- Reset asserted mid-frame discards the partial frame and any pending `dout`.
- Latency: with `start` high at cycle 0 and `bit_en` high every cycle from cycle 1, the bits are accepted in cycles 1..WIDTH and `dout_valid` is first high in cycle WIDTH+1.
- Gaps in `bit_en` stretch the frame without limit; there is no timeout.
- Minimum frame-to-frame spacing: `start` may be asserted in the first IDLE cycle after completion, giving a period of WIDTH+1 cycles at full rate.
- `busy` rises one cycle after an accepted `start` and falls on the edge after the completion cycle.

## Test plan
- **Basic frame:** reset, `start`, then bits 1,1,0 on consecutive cycles (WIDTH=3) -> `shift_en` high for those 3 cycles; `dout`=3'b110 and `dout_valid`=1 in cycle 4; `busy` high in cycles 1–3.
- **Gapped input:** `start`, then bits 1,0,1 with `bit_en` low for 2 cycles between each bit -> `dout`=3'b101; `bit_cnt` steps 0→1→2 and holds its value during the gaps.
- **Overrun:** complete frame A=3'b011 with `dout_ready`=0, then complete frame B=3'b100 -> `dout` stays 3'b011 and `overrun`=1; assert `clr_ovr` -> `overrun`=0.
- **Back-to-back with consume:** `dout_valid`=1 with 3'b011, and `dout_ready`=1 in the same cycle that frame 3'b111 completes -> `dout`=3'b111 and `dout_valid` stays 1, with no overrun.
- **Ignored controls:** assert `start` mid-frame after 1 bit -> `bit_cnt` unchanged and the frame completes normally. Assert `bit_en`=1 with `start` in IDLE -> that bit is not counted.
- **Reset mid-frame:** after 2 bits, pulse `reset` -> all outputs 0 immediately, no `dout_valid`; a subsequent full frame 3'b010 is received correctly.

Source files
------------

// File: rtl/sipo_frame_ctrl.sv
// Frame controller for a serial-in/parallel-out path: gates serial bits into a
// WIDTH-bit shift register, counts them, and offers each word on valid/ready.
module sipo_frame_ctrl #(
    parameter int unsigned WIDTH = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         sin,
    input  logic                         bit_en,
    input  logic                         dout_ready,
    input  logic                         clr_ovr,
    output logic                         shift_en,
    output logic                         busy,
    output logic [$clog2(WIDTH+1)-1:0]   bit_cnt,
    output logic [WIDTH-1:0]             dout,
    output logic                         dout_valid,
    output logic                         overrun
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] word;
    logic             complete;
    logic             load;
    logic             drop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        shift_en = 1'b0;
        busy     = 1'b0;
        complete = 1'b0;
        word     = {sh[WIDTH-2:0], sin};
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                busy     = 1'b1;
                shift_en = bit_en;
                if (bit_en && (bit_cnt == CW'(WIDTH - 1))) begin
                    complete = 1'b1;
                    state_n  = IDLE;
                end
            end
        endcase
        // A pending word consumed in the completion cycle frees the slot.
        load = complete && (!dout_valid || dout_ready);
        drop = complete && !load;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh         <= '0;
            bit_cnt    <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (state == IDLE) begin
                if (start) begin
                    sh      <= '0;
                    bit_cnt <= '0;
                end
            end else if (bit_en) begin
                sh      <= word;
                bit_cnt <= complete ? '0 : bit_cnt + CW'(1);
            end

            if (load) begin
                dout       <= word;
                dout_valid <= 1'b1;
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end

            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
